// File: rtl/keypad_scan_fifo.sv
// Keypad front end: synchronises and debounces a 74C922-style encoder, decodes one key
// value per press and queues the values in a first-word fall-through FIFO.
module keypad_scan_fifo #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DEPTH           = 8,
  parameter bit DECODE_EN       = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               enc_code,
  input  logic                     key_avail,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [3:0]               key_code,
  output logic                     key_is_op,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  function automatic logic [3:0] decode_key(input logic [3:0] c);
    logic [3:0] v;
    case (c)
      4'b1000: v = 4'h0;
      4'b0011: v = 4'h1;
      4'b1011: v = 4'h2;
      4'b0111: v = 4'h3;
      4'b0001: v = 4'h4;
      4'b1001: v = 4'h5;
      4'b0101: v = 4'h6;
      4'b0010: v = 4'h7;
      4'b1010: v = 4'h8;
      4'b0110: v = 4'h9;
      4'b1100: v = 4'hA;
      4'b1110: v = 4'hB;
      4'b1101: v = 4'hC;
      4'b1111: v = 4'hD;
      4'b0100: v = 4'hE;
      default: v = 4'hF;
    endcase
    return DECODE_EN ? v : c;
  endfunction

  logic [SYNC_STAGES-1:0] avail_sync;
  logic [3:0]             code_sync [SYNC_STAGES];
  logic                   avail_s;
  logic [3:0]             code_s;

  // Synchroniser stage: code and strobe share the same delay so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) code_sync[i] <= 4'h0;
    end else begin
      avail_sync   <= {avail_sync[SYNC_STAGES-2:0], key_avail};
      code_sync[0] <= enc_code;
      for (int i = 1; i < SYNC_STAGES; i++) code_sync[i] <= code_sync[i-1];
    end
  end

  assign avail_s = avail_sync[SYNC_STAGES-1];
  assign code_s  = code_sync[SYNC_STAGES-1];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code_q;
  logic             push_req;
  logic             load_code;
  logic [3:0]       push_data;

  // push_req fires on the edge that completes debouncing; code_s equals code_q then.
  always_comb begin
    push_req  = 1'b0;
    load_code = 1'b0;
    case (state)
      IDLE: begin
        push_req  = avail_s && (DEBOUNCE_CYCLES == 1);
        load_code = avail_s;
      end
      PRESS_WAIT: begin
        push_req  = avail_s && (code_s == code_q) && (cnt == CNT_LAST);
        load_code = avail_s && (code_s != code_q);
      end
      default: ;
    endcase
  end

  assign push_data = decode_key(code_s);

  always_ff @(posedge clk) begin
    if (load_code) code_q <= code_s;
  end

  // Debounce stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (avail_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= HELD;
            end else begin
              cnt   <= CNT_W'(1);
              state <= PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (!avail_s)                 state <= IDLE;
          else if (code_s != code_q)    cnt   <= CNT_W'(1);
          else if (cnt == CNT_LAST)     state <= HELD;
          else                          cnt   <= cnt + CNT_W'(1);
        end
        HELD: begin
          if (!avail_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= IDLE;
            end else begin
              cnt   <= CNT_W'(1);
              state <= RELEASE_WAIT;
            end
          end
        end
        RELEASE_WAIT: begin
          if (avail_s)                  state <= HELD;
          else if (cnt == CNT_LAST)     state <= IDLE;
          else                          cnt   <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;

  assign pop     = out_valid && out_ready;
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FIFO stage: a pop on a full FIFO frees the slot for a same-edge push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign out_valid  = (count != '0);
  assign key_code   = out_valid ? mem[rd_ptr] : 4'h0;
  assign key_is_op  = out_valid && (key_code >= 4'hA);
  assign fifo_count = count;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: SYNC=2, DEB=4, DEPTH=8, plus a raw-code instance.
module tb_keypad_scan_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] enc_code;
  logic       key_avail;
  logic       out_ready;
  logic       clr_ovf;
  logic       out_valid, out_valid2;
  logic [3:0] key_code, key_code2;
  logic       key_is_op, key_is_op2;
  logic [3:0] fifo_count, fifo_count2;
  logic       overflow, overflow2;

  int errors = 0;
  int checks = 0;

  keypad_scan_fifo #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .DEPTH(8), .DECODE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .enc_code(enc_code), .key_avail(key_avail),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid), .key_code(key_code),
    .key_is_op(key_is_op), .fifo_count(fifo_count), .overflow(overflow)
  );

  keypad_scan_fifo #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .DEPTH(8), .DECODE_EN(1'b0)) dut_raw (
    .clk(clk), .rst_n(rst_n), .enc_code(enc_code), .key_avail(key_avail),
    .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid2), .key_code(key_code2),
    .key_is_op(key_is_op2), .fifo_count(fifo_count2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  // Raw encoder codes for key values 0..F.
  logic [3:0] raw_of [16] = '{4'b1000, 4'b0011, 4'b1011, 4'b0111, 4'b0001, 4'b1001,
                              4'b0101, 4'b0010, 4'b1010, 4'b0110, 4'b1100, 4'b1110,
                              4'b1101, 4'b1111, 4'b0100, 4'b0000};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] raw);
    enc_code  = raw;
    key_avail = 1'b1;
    tick(8);
    key_avail = 1'b0;
    tick(10);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    enc_code = 4'h0; key_avail = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    do_reset();
    checks++;
    if ({out_valid, key_code, key_is_op, fifo_count, overflow} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b code=%0h op=%0b cnt=%0d ovf=%0b want all 0",
               out_valid, key_code, key_is_op, fifo_count, overflow);
    end
  endtask

  task automatic test_single_press();
    enc_code  = 4'b1001;
    key_avail = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checks++;
      if (out_valid !== (k >= 6)) begin
        errors++;
        $display("FAIL latency_edge%0d got out_valid=%0b want %0b", k, out_valid, k >= 6);
      end
    end
    tick(14);
    checks++;
    if (fifo_count !== 4'd1 || key_code !== 4'h5 || key_is_op !== 1'b0) begin
      errors++;
      $display("FAIL single_press got cnt=%0d code=%0h op=%0b want 1/5/0",
               fifo_count, key_code, key_is_op);
    end
    key_avail = 1'b0;
    tick(10);
    pop_one();
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL single_pop got cnt=%0d valid=%0b code=%0h want 0/0/0",
               fifo_count, out_valid, key_code);
    end
  endtask

  task automatic test_glitch();
    enc_code = 4'b0011;
    for (int p = 0; p < 5; p++) begin
      key_avail = 1'b1;
      tick(3);
      key_avail = 1'b0;
      tick(4);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch_pulse%0d got out_valid=%0b want 0", p, out_valid);
      end
    end
    checks++;
    if (fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL glitch_count got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_code_change();
    enc_code  = 4'b0000;
    key_avail = 1'b1;
    tick(2);
    enc_code = 4'b1111;
    tick(5);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL change_early got out_valid=%0b want 0", out_valid);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL change_push got out_valid=%0b want 1", out_valid);
    end
    tick(10);
    checks++;
    if (fifo_count !== 4'd1 || key_code !== 4'hD || key_is_op !== 1'b1) begin
      errors++;
      $display("FAIL change_entry got cnt=%0d code=%0h op=%0b want 1/D/1",
               fifo_count, key_code, key_is_op);
    end
    key_avail = 1'b0;
    tick(10);
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) press(raw_of[i]);
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_no_ovf got cnt=%0d ovf=%0b want 8/0", fifo_count, overflow);
    end
    press(raw_of[8]);
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got cnt=%0d ovf=%0b want 8/1", fifo_count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (key_code !== 4'(i)) begin
        errors++;
        $display("FAIL drain_order%0d got %0h want %0h", i, key_code, i);
      end
      pop_one();
    end
    checks++;
    if (fifo_count !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained got cnt=%0d ovf=%0b want 0/1", fifo_count, overflow);
    end
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf got %0b want 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) press(raw_of[i]);
    enc_code  = raw_of[9];
    key_avail = 1'b1;
    tick(5);
    checks++;
    if (fifo_count !== 4'd8 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL b2b_before got cnt=%0d head=%0h want 8/0", fifo_count, key_code);
    end
    pop_one();
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b0 || key_code !== 4'h1) begin
      errors++;
      $display("FAIL b2b_same_edge got cnt=%0d ovf=%0b head=%0h want 8/0/1",
               fifo_count, overflow, key_code);
    end
    key_avail = 1'b0;
    tick(10);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (key_code !== ((i == 8) ? 4'h9 : 4'(i))) begin
        errors++;
        $display("FAIL b2b_order%0d got %0h want %0h", i, key_code, (i == 8) ? 9 : i);
      end
      pop_one();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) press(raw_of[i + 2]);
    checks++;
    if (fifo_count !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset_count got %0d want 3", fifo_count);
    end
    enc_code  = 4'b0110;
    key_avail = 1'b1;
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, key_code, key_is_op, fifo_count, overflow} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got valid=%0b code=%0h op=%0b cnt=%0d ovf=%0b want all 0",
               out_valid, key_code, key_is_op, fifo_count, overflow);
    end
    tick(2);
    rst_n = 1'b1;
    tick(5);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL repress_early got out_valid=%0b want 0", out_valid);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b1 || key_code !== 4'h9) begin
      errors++;
      $display("FAIL repress got valid=%0b code=%0h want 1/9", out_valid, key_code);
    end
    checks++;
    if (out_valid2 !== 1'b1 || key_code2 !== 4'h6 || key_is_op2 !== 1'b0) begin
      errors++;
      $display("FAIL raw_passthrough got valid=%0b code=%0h op=%0b want 1/6/0",
               out_valid2, key_code2, key_is_op2);
    end
    key_avail = 1'b0;
    tick(10);
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_single_press();
    test_glitch();
    test_code_change();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
